// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory between a CPU port and a DMA/loader port.
// Ports: clk, rst (async, active-low), cpu_*/dma_* requester ports,
//        mem_* registered memory bus, bus_err timeout pulse, busy.
module mem_arbiter #(
   parameter int AW           = 32,
   parameter int DW           = 32,
   parameter int MAX_WAIT     = 15,
   parameter int STARVE_LIMIT = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_adr,
   input  logic [DW-1:0] cpu_wd,
   output logic [DW-1:0] cpu_rd,
   output logic          cpu_ack,
   input  logic          dma_req,
   input  logic          dma_we,
   input  logic [AW-1:0] dma_adr,
   input  logic [DW-1:0] dma_wd,
   output logic [DW-1:0] dma_rd,
   output logic          dma_ack,
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_adr,
   output logic [DW-1:0] mem_wd,
   input  logic [DW-1:0] mem_rd,
   input  logic          mem_ready,
   output logic          bus_err,
   output logic          busy
);

   localparam int WCW = $clog2(MAX_WAIT + 1);
   localparam int SCW = $clog2(STARVE_LIMIT + 1);

   typedef enum logic [2:0] {
      IDLE,
      BUSY_CPU,
      BUSY_DMA,
      DONE_CPU,
      DONE_DMA
   } state_t;

   state_t         state, state_nxt;
   logic [WCW-1:0] wait_cnt;
   logic [SCW-1:0] starve_cnt;
   logic           err;

   logic grant_cpu, grant_dma;
   logic finish, abort;
   logic dma_forced;

   // DMA wins a tie only once the CPU has starved it long enough.
   assign dma_forced = dma_req && (starve_cnt == SCW'(STARVE_LIMIT));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      grant_cpu = 1'b0;
      grant_dma = 1'b0;
      finish    = 1'b0;
      abort     = 1'b0;
      case (state)
         IDLE: begin
            if (cpu_req && !dma_forced) begin
               grant_cpu = 1'b1;
               state_nxt = BUSY_CPU;
            end else if (dma_req) begin
               grant_dma = 1'b1;
               state_nxt = BUSY_DMA;
            end
         end
         BUSY_CPU, BUSY_DMA: begin
            if (mem_ready) begin
               finish    = 1'b1;
            end else if (wait_cnt == WCW'(MAX_WAIT - 1)) begin
               abort     = 1'b1;
            end
            if (finish || abort)
               state_nxt = (state == BUSY_CPU) ? DONE_CPU : DONE_DMA;
         end
         DONE_CPU, DONE_DMA: state_nxt = IDLE;
         default:            state_nxt = IDLE;
      endcase
   end

   assign cpu_ack = (state == DONE_CPU);
   assign dma_ack = (state == DONE_DMA);
   assign bus_err = (cpu_ack || dma_ack) && err;
   assign busy    = (state != IDLE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_adr    <= '0;
         mem_wd     <= '0;
         cpu_rd     <= '0;
         dma_rd     <= '0;
         wait_cnt   <= '0;
         starve_cnt <= '0;
         err        <= 1'b0;
      end else begin
         if (grant_cpu) begin
            mem_req  <= 1'b1;
            mem_we   <= cpu_we;
            mem_adr  <= cpu_adr;
            mem_wd   <= cpu_wd;
            wait_cnt <= '0;
            err      <= 1'b0;
            if (dma_req && starve_cnt != SCW'(STARVE_LIMIT))
               starve_cnt <= starve_cnt + SCW'(1);
         end
         if (grant_dma) begin
            mem_req    <= 1'b1;
            mem_we     <= dma_we;
            mem_adr    <= dma_adr;
            mem_wd     <= dma_wd;
            wait_cnt   <= '0;
            err        <= 1'b0;
            starve_cnt <= '0;
         end
         if (finish) begin
            mem_req <= 1'b0;
            if (!mem_we) begin
               if (state == BUSY_CPU) cpu_rd <= mem_rd;
               else                   dma_rd <= mem_rd;
            end
         end else if (abort) begin
            mem_req <= 1'b0;
            err     <= 1'b1;
            // A timed-out read returns zero rather than stale data.
            if (!mem_we) begin
               if (state == BUSY_CPU) cpu_rd <= '0;
               else                   dma_rd <= '0;
            end
         end else if (mem_req) begin
            wait_cnt <= wait_cnt + WCW'(1);
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vectors plus multi-cycle sequences for
// mem_arbiter (grant latency, starvation, timeout, back-to-back, reset).
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_req, cpu_we, dma_req, dma_we;
   logic [31:0] cpu_adr, cpu_wd, dma_adr, dma_wd;
   logic [31:0] cpu_rd, dma_rd, mem_adr, mem_wd, mem_rd;
   logic        cpu_ack, dma_ack, mem_req, mem_we, mem_ready;
   logic        bus_err, busy;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mem_arbiter #(
      .AW(32), .DW(32), .MAX_WAIT(15), .STARVE_LIMIT(4)
   ) dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr),
      .cpu_wd(cpu_wd), .cpu_rd(cpu_rd), .cpu_ack(cpu_ack),
      .dma_req(dma_req), .dma_we(dma_we), .dma_adr(dma_adr),
      .dma_wd(dma_wd), .dma_rd(dma_rd), .dma_ack(dma_ack),
      .mem_req(mem_req), .mem_we(mem_we), .mem_adr(mem_adr),
      .mem_wd(mem_wd), .mem_rd(mem_rd), .mem_ready(mem_ready),
      .bus_err(bus_err), .busy(busy)
   );

   typedef struct {
      logic        creq, cwe;
      logic [31:0] cadr, cwd;
      logic        dreq, dwe;
      logic [31:0] dadr, dwd;
      logic [31:0] mrd;
      logic        mrdy;
      logic        emreq, emwe;
      logic [31:0] emadr, emwd;
      logic        ecack, edack;
      logic [31:0] ecrd, edrd;
      logic        eerr, ebusy;
   } vec_t;

   localparam logic H = 1'b1;
   localparam logic L = 1'b0;
   localparam logic [31:0] Z = 32'h0;
   localparam logic [31:0] DB = 32'hDEADBEEF;
   localparam logic [31:0] WD = 32'h12345678;
   localparam logic [31:0] CF = 32'hCAFEF00D;

   task automatic chk1(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%b required=%b", nm, act, exp);
      end
   endtask

   task automatic chk32(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_adr = Z; cpu_wd = Z;
      dma_req = 1'b0; dma_we = 1'b0; dma_adr = Z; dma_wd = Z;
      mem_rd = Z; mem_ready = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   vec_t vt[13];
   logic [1:0] ord[10];
   int k;

   initial begin
      vt[0]  = '{H,L,32'h40,Z, L,L,Z,Z, Z,L,
                 L,L,Z,Z, L,L,Z,Z, L,L};
      vt[1]  = '{H,L,32'h40,Z, L,L,Z,Z, DB,H,
                 H,L,32'h40,Z, L,L,Z,Z, L,H};
      vt[2]  = '{H,L,32'h40,Z, L,L,Z,Z, Z,L,
                 L,L,32'h40,Z, H,L,DB,Z, L,H};
      vt[3]  = '{L,L,Z,Z, H,H,32'h100,WD, Z,L,
                 L,L,32'h40,Z, L,L,DB,Z, L,L};
      vt[4]  = '{L,L,Z,Z, H,H,32'h100,WD, Z,L,
                 H,H,32'h100,WD, L,L,DB,Z, L,H};
      vt[5]  = vt[4];
      vt[6]  = vt[4];
      vt[7]  = '{L,L,Z,Z, H,H,32'h100,WD, 32'hFFFFFFFF,H,
                 H,H,32'h100,WD, L,L,DB,Z, L,H};
      vt[8]  = '{L,L,Z,Z, H,H,32'h100,WD, Z,L,
                 L,H,32'h100,WD, L,H,DB,Z, L,H};
      vt[9]  = '{L,L,Z,Z, H,L,32'h200,Z, Z,L,
                 L,H,32'h100,WD, L,L,DB,Z, L,L};
      vt[10] = '{L,L,Z,Z, H,L,32'h200,Z, CF,H,
                 H,L,32'h200,Z, L,L,DB,Z, L,H};
      vt[11] = '{L,L,Z,Z, H,L,32'h200,Z, Z,L,
                 L,L,32'h200,Z, L,H,DB,CF, L,H};
      vt[12] = '{L,L,Z,Z, L,L,Z,Z, Z,L,
                 L,L,32'h200,Z, L,L,DB,CF, L,L};

      ord = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01,
              2'b10, 2'b10, 2'b10, 2'b10, 2'b01};

      // reset state
      rst = 1'b0;
      idle_inputs();
      step();
      step();
      chk1("rst mem_req", mem_req, 1'b0);
      chk1("rst busy", busy, 1'b0);
      chk1("rst cpu_ack", cpu_ack, 1'b0);
      chk1("rst dma_ack", dma_ack, 1'b0);
      chk32("rst mem_adr", mem_adr, Z);
      chk32("rst cpu_rd", cpu_rd, Z);
      rst = 1'b1;

      // table: CPU read, DMA write with 3 wait cycles, DMA read
      for (int i = 0; i < 13; i++) begin
         cpu_req = vt[i].creq; cpu_we = vt[i].cwe;
         cpu_adr = vt[i].cadr; cpu_wd = vt[i].cwd;
         dma_req = vt[i].dreq; dma_we = vt[i].dwe;
         dma_adr = vt[i].dadr; dma_wd = vt[i].dwd;
         mem_rd  = vt[i].mrd;  mem_ready = vt[i].mrdy;
         #1;
         chk1($sformatf("row%0d mem_req", i), mem_req, vt[i].emreq);
         chk1($sformatf("row%0d mem_we", i), mem_we, vt[i].emwe);
         chk32($sformatf("row%0d mem_adr", i), mem_adr, vt[i].emadr);
         chk32($sformatf("row%0d mem_wd", i), mem_wd, vt[i].emwd);
         chk1($sformatf("row%0d cpu_ack", i), cpu_ack, vt[i].ecack);
         chk1($sformatf("row%0d dma_ack", i), dma_ack, vt[i].edack);
         chk32($sformatf("row%0d cpu_rd", i), cpu_rd, vt[i].ecrd);
         chk32($sformatf("row%0d dma_rd", i), dma_rd, vt[i].edrd);
         chk1($sformatf("row%0d bus_err", i), bus_err, vt[i].eerr);
         chk1($sformatf("row%0d busy", i), busy, vt[i].ebusy);
         step();
      end

      // starvation: both request continuously
      idle_inputs();
      cpu_req = 1'b1; cpu_adr = 32'h10;
      dma_req = 1'b1; dma_adr = 32'h20;
      mem_rd = 32'h11111111; mem_ready = 1'b1;
      k = 0;
      for (int c = 0; c < 30; c++) begin
         #1;
         if (cpu_ack || dma_ack) begin
            if (k < 10)
               chk32($sformatf("starve order%0d", k),
                     32'({cpu_ack, dma_ack}), 32'(ord[k]));
            k++;
         end
         step();
      end
      cpu_req = 1'b0; dma_req = 1'b0;
      chk32("starve ack count", k, 32'd10);
      chk32("starve cpu_rd", cpu_rd, 32'h11111111);
      step();
      chk1("starve idle", busy, 1'b0);

      // timeout: mem_ready stuck low
      idle_inputs();
      mem_rd = 32'hFFFFFFFF;
      cpu_req = 1'b1; cpu_adr = 32'h80;
      step();
      for (int c = 1; c <= 15; c++) begin
         chk1($sformatf("tmo c%0d mem_req", c), mem_req, 1'b1);
         chk1($sformatf("tmo c%0d cpu_ack", c), cpu_ack, 1'b0);
         step();
      end
      cpu_req = 1'b0;
      chk1("tmo c16 cpu_ack", cpu_ack, 1'b1);
      chk1("tmo c16 bus_err", bus_err, 1'b1);
      chk1("tmo c16 mem_req", mem_req, 1'b0);
      chk32("tmo c16 cpu_rd", cpu_rd, Z);
      step();
      chk1("tmo c17 busy", busy, 1'b0);
      chk1("tmo c17 bus_err", bus_err, 1'b0);

      // back-to-back CPU with DMA pending below the starve limit
      idle_inputs();
      cpu_req = 1'b1; cpu_adr = 32'h48;
      dma_req = 1'b1; dma_adr = 32'h20;
      mem_rd = 32'hA5A5A5A5; mem_ready = 1'b1;
      step();
      chk1("b2b c1 mem_req", mem_req, 1'b1);
      chk32("b2b c1 mem_adr", mem_adr, 32'h48);
      step();
      chk1("b2b c2 cpu_ack", cpu_ack, 1'b1);
      chk1("b2b c2 dma_ack", dma_ack, 1'b0);
      chk1("b2b c2 bus_err", bus_err, 1'b0);
      chk32("b2b c2 cpu_rd", cpu_rd, 32'hA5A5A5A5);
      cpu_adr = 32'h4C;
      step();
      chk1("b2b c3 busy", busy, 1'b0);
      step();
      chk1("b2b c4 mem_req", mem_req, 1'b1);
      chk32("b2b c4 mem_adr", mem_adr, 32'h4C);
      step();
      chk1("b2b c5 cpu_ack", cpu_ack, 1'b1);
      chk1("b2b c5 dma_ack", dma_ack, 1'b0);
      cpu_req = 1'b0; dma_req = 1'b0;
      step();

      // reset in the middle of a CPU transaction
      idle_inputs();
      cpu_req = 1'b1; cpu_adr = 32'h60; cpu_wd = 32'h77;
      step();
      chk1("rmid c1 mem_req", mem_req, 1'b1);
      step();
      rst = 1'b0;
      cpu_req = 1'b0;
      #1;
      chk1("rmid mem_req", mem_req, 1'b0);
      chk1("rmid busy", busy, 1'b0);
      chk1("rmid cpu_ack", cpu_ack, 1'b0);
      chk1("rmid bus_err", bus_err, 1'b0);
      chk32("rmid mem_adr", mem_adr, Z);
      chk32("rmid cpu_rd", cpu_rd, Z);
      step();
      step();
      rst = 1'b1;
      for (int c = 0; c < 5; c++) begin
         chk1($sformatf("post c%0d ack", c), cpu_ack | dma_ack, 1'b0);
         chk1($sformatf("post c%0d busy", c), busy, 1'b0);
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single unified instruction/data memory of the multicycle MIPS core between the CPU controller (fetch, lw, sw) and a DMA/program-loader port. It sequences one memory transaction at a time over a req/ready handshake with a variable-latency memory, returns read data and a one-cycle acknowledge to the winning requester, and aborts with an error pulse on memory timeout. CPU has priority; a starvation counter guarantees DMA forward progress.

## Interface
- AW, 32, address width
- DW, 32, data width
- MAX_WAIT, 15, max cycles mem_req may stay high without mem_ready (>=1)
- STARVE_LIMIT, 4, consecutive CPU grants while DMA waits before DMA is forced (>=1)

- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- cpu_req / dma_req  in  1  transaction request; held with we/adr/wd stable until ack
- cpu_we / dma_we  in  1  1 = write, 0 = read
- cpu_adr / dma_adr  in  AW  byte address
- cpu_wd / dma_wd  in  DW  write data
- cpu_rd / dma_rd  out  DW  registered read data, held until next completed read on that port
- cpu_ack / dma_ack  out  1  one-cycle completion pulse
- mem_req  out  1  registered memory request
- mem_we  out  1  registered write enable
- mem_adr  out  AW  registered address
- mem_wd  out  DW  registered write data
- mem_rd  in  DW  memory read data, valid when mem_ready
- mem_ready  in  1  memory completes transaction in this cycle
- bus_err  out  1  one-cycle pulse coincident with ack of an aborted transaction
- busy  out  1  state != IDLE

## Operation
- States: IDLE, BUSY_CPU, BUSY_DMA, DONE_CPU, DONE_DMA.
- IDLE: arbitrate on registered inputs. Only one req → grant it. Both → CPU, unless starve_cnt == STARVE_LIMIT, then DMA. Neither → stay.
- On grant: latch we/adr/wd into mem_we/mem_adr/mem_wd, set mem_req=1, clear wait_cnt, go BUSY_x.
- starve_cnt: +1 on CPU grant while dma_req=1 (saturates at STARVE_LIMIT); cleared on any DMA grant; unchanged otherwise.
- BUSY_x with mem_ready=1: if read, capture mem_rd into x_rd; clear mem_req; go DONE_x.
- BUSY_x with mem_ready=0: if wait_cnt == MAX_WAIT-1, abort: clear mem_req, x_rd := 0 (reads only), set err flag, go DONE_x; else wait_cnt+1.
- DONE_x: x_ack=1, bus_err=err flag, for exactly this cycle; go IDLE; req inputs ignored in DONE.
- Writes never modify x_rd. mem_adr/mem_wd/mem_we hold last values when mem_req=0.
- Requester seeing ack must drop req next cycle or present a new transaction; req still high in the IDLE cycle after DONE is a new request.
- Non-granted requester waits with req high; no ack, no data change.

## Timing
- Reset (rst=0, async): state IDLE; mem_req, mem_we, cpu_ack, dma_ack, bus_err, busy = 0; mem_adr, mem_wd, cpu_rd, dma_rd = 0; wait_cnt, starve_cnt, err flag = 0. Reset mid-transaction drops it: no ack, no err.
- Min latency (mem_ready high): req seen cycle 0 → mem_req cycle 1 → ack + rd valid cycle 2 → IDLE cycle 3. Throughput: one transaction per 3 cycles.
- Each extra mem_ready-low cycle adds one cycle.
- Timeout: mem_req high exactly MAX_WAIT cycles, ack+bus_err the next cycle.
- mem_ready sampled only while mem_req=1; ignored in other states.

## Test plan
- Reset: rst=0 mid-BUSY_CPU with mem_ready=0 → all outputs 0 immediately; after release no ack on either port.
- CPU read, mem_ready=1, adr=0x40, mem_rd=0xDEADBEEF → mem_req cycle 1 with mem_adr=0x40, cpu_ack cycle 2, cpu_rd=0xDEADBEEF, bus_err=0.
- DMA write adr=0x100 wd=0x12345678, mem_ready low 3 cycles → mem_req high cycles 1–4, mem_we=1, dma_ack cycle 5, dma_rd unchanged.
- Both requesting continuously, STARVE_LIMIT=4 → grant order CPU,CPU,CPU,CPU,DMA,CPU…; starve_cnt returns to 0 after DMA grant.
- mem_ready tied 0, MAX_WAIT=15, CPU read → mem_req high cycles 1–15, cpu_ack and bus_err high cycle 16, cpu_rd=0, busy=0 cycle 17.
- Back-to-back: CPU keeps req high after ack → new grant in IDLE cycle 3, mem_req cycle 4; pending DMA req with starve_cnt<limit stays ungranted.
